// File: rtl/pipe_geom_pkg.sv
// Shared pipe/bird geometry and the collision FSM state encoding.
// Used by the pipe generator, the VGA logic and pipe_collision.
package pipe_geom_pkg;

    localparam logic [11:0] BIRD_X      = 12'd300;
    localparam logic [11:0] BIRD_HALF   = 12'd16;
    localparam logic [11:0] PIPE_HALF_W = 12'd40;
    localparam logic [11:0] GAP_HALF    = 12'd90;
    localparam logic [11:0] SCREEN_H    = 12'd768;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    // One scanned pipe sample as held in the first pipeline stage.
    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] by;
        logic [1:0]  idx;
    } scan_t;

    // Lower bounds clamp at 0 so pipes near the screen edge cannot wrap.
    function automatic logic [12:0] sat_sub(input logic [12:0] a, input logic [12:0] b);
        return (a >= b) ? (a - b) : 13'd0;
    endfunction

endpackage

// File: rtl/pipe_collision_box_check.sv
// Combinational bird-vs-one-pipe overlap test (square bird box vs pipe with gap).
module pipe_box_check
    import pipe_geom_pkg::*;
(
    input  logic [11:0] x_i,
    input  logic [11:0] y_i,
    input  logic [11:0] by_i,
    output logic        hit_o
);

    logic [12:0] x, y, by;
    logic        horiz, ingap;

    assign x  = {1'b0, x_i};
    assign y  = {1'b0, y_i};
    assign by = {1'b0, by_i};

    assign horiz = ({1'b0, BIRD_X} + {1'b0, BIRD_HALF} >= sat_sub(x, {1'b0, PIPE_HALF_W}))
                && ({1'b0, BIRD_X} - {1'b0, BIRD_HALF} <= x + {1'b0, PIPE_HALF_W});

    // Strict compares: touching a gap edge is a collision.
    assign ingap = (sat_sub(by, {1'b0, BIRD_HALF}) > sat_sub(y, {1'b0, GAP_HALF}))
                && (by + {1'b0, BIRD_HALF} < y + {1'b0, GAP_HALF});

    // x == 0 marks a pipe in its respawn cycle.
    assign hit_o = (x_i != 12'd0) && horiz && !ingap;

endmodule

// File: rtl/pipe_collision.sv
// Round-robin pipe collision detector driving the game-over flag.
// Optional screen-border collision is enabled by defining COLLISION_BORDER_EN.
module pipe_collision
    import pipe_geom_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        is_start,
    input  logic        restart,
    input  logic [11:0] bpos_y,
    input  logic [11:0] pippos_x1,
    input  logic [11:0] pippos_x2,
    input  logic [11:0] pippos_x3,
    input  logic [11:0] pippos_y1,
    input  logic [11:0] pippos_y2,
    input  logic [11:0] pippos_y3,
    output logic        is_over,
    output logic        hit_valid,
    output logic [1:0]  hit_idx
);

    logic [1:0] state_q, state_d, idx_q, idx_d;
    scan_t      s1_q, s1_d;
    logic       s1_vld_q, s1_vld_d, s1_border_q, s1_border_d;
    logic       s2_hit_q, s2_hit_d;
    logic [1:0] s2_idx_q, s2_idx_d;
    logic       is_over_q, is_over_d, hit_valid_q, hit_valid_d;
    logic [1:0] hit_idx_q, hit_idx_d;
    logic       pipe_hit, border_now;

    always_comb begin
        s1_d.by  = bpos_y;
        s1_d.idx = idx_q;
        case (idx_q)
            2'd2:    begin s1_d.x = pippos_x2; s1_d.y = pippos_y2; end
            2'd3:    begin s1_d.x = pippos_x3; s1_d.y = pippos_y3; end
            default: begin s1_d.x = pippos_x1; s1_d.y = pippos_y1; end
        endcase
    end

`ifdef COLLISION_BORDER_EN
    assign border_now = (bpos_y < BIRD_HALF)
                     || ({1'b0, bpos_y} + {1'b0, BIRD_HALF} >= {1'b0, SCREEN_H});
`else
    assign border_now = 1'b0;
`endif

    pipe_box_check u_box (
        .x_i   (s1_q.x),
        .y_i   (s1_q.y),
        .by_i  (s1_q.by),
        .hit_o (pipe_hit)
    );

    // Stage valids are gated by RUN so hits in flight die when RUN is left.
    assign s1_vld_d    = (state_q == ST_RUN);
    assign s1_border_d = border_now;
    assign s2_hit_d    = s1_vld_q && (state_q == ST_RUN) && (pipe_hit || s1_border_q);
    assign s2_idx_d    = pipe_hit ? s1_q.idx : 2'd0;

    always_comb begin
        state_d = state_q;
        idx_d   = 2'd0;
        case (state_q)
            ST_IDLE: if (is_start) begin
                state_d = ST_RUN;
                idx_d   = 2'd1;
            end
            ST_RUN: begin
                idx_d = (idx_q == 2'd3) ? 2'd1 : idx_q + 2'd1;
                if (!is_start) begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
                end else if (s2_hit_q) begin
                    state_d = ST_OVER;
                    idx_d   = 2'd0;
                end
            end
            ST_OVER: if (restart) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign is_over_d   = (state_d == ST_OVER);
    assign hit_valid_d = (state_q == ST_RUN) && (state_d == ST_OVER);
    assign hit_idx_d   = hit_valid_d ? s2_idx_q
                       : (state_d == ST_OVER) ? hit_idx_q : 2'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            s1_q        <= '0;
            s1_vld_q    <= 1'b0;
            s1_border_q <= 1'b0;
            s2_hit_q    <= 1'b0;
            s2_idx_q    <= 2'd0;
            is_over_q   <= 1'b0;
            hit_valid_q <= 1'b0;
            hit_idx_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            s1_q        <= s1_d;
            s1_vld_q    <= s1_vld_d;
            s1_border_q <= s1_border_d;
            s2_hit_q    <= s2_hit_d;
            s2_idx_q    <= s2_idx_d;
            is_over_q   <= is_over_d;
            hit_valid_q <= hit_valid_d;
            hit_idx_q   <= hit_idx_d;
        end
    end

    assign is_over   = is_over_q;
    assign hit_valid = hit_valid_q;
    assign hit_idx   = hit_idx_q;

endmodule

// File: tb/tb_pipe_collision.sv
// Randomized self-checking bench for pipe_collision against a geometric model.
module tb_pipe_collision;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        is_start = 1'b0;
    logic        restart = 1'b0;
    logic [11:0] bpos_y = '0;
    logic [11:0] pippos_x1 = '0, pippos_x2 = '0, pippos_x3 = '0;
    logic [11:0] pippos_y1 = '0, pippos_y2 = '0, pippos_y3 = '0;
    logic        is_over, hit_valid;
    logic [1:0]  hit_idx;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_collision dut (
        .clk       (clk),
        .rst       (rst),
        .is_start  (is_start),
        .restart   (restart),
        .bpos_y    (bpos_y),
        .pippos_x1 (pippos_x1),
        .pippos_x2 (pippos_x2),
        .pippos_x3 (pippos_x3),
        .pippos_y1 (pippos_y1),
        .pippos_y2 (pippos_y2),
        .pippos_y3 (pippos_y3),
        .is_over   (is_over),
        .hit_valid (hit_valid),
        .hit_idx   (hit_idx)
    );

    // Geometry model: bird box [284,316] x [by-16,by+16], pipe columns x+-40,
    // gap rows y+-90 (open interval); lower bounds clamp at 0.
    function automatic bit model_hit(input int x, input int y, input int by);
        int pl, gt, bt;
        bit horiz, ingap;
        if (x == 0) return 1'b0;
        pl = (x - 40 < 0) ? 0 : x - 40;
        gt = (y - 90 < 0) ? 0 : y - 90;
        bt = (by - 16 < 0) ? 0 : by - 16;
        horiz = (316 >= pl) && (284 <= x + 40);
        ingap = (bt > gt) && (by + 16 < y + 90);
        return horiz && !ingap;
    endfunction

    function automatic bit model_border(input int by);
`ifdef COLLISION_BORDER_EN
        return (by < 16) || (by + 16 >= 768);
`else
        return (by < 0);
`endif
    endfunction

    task automatic drive(input int x1, input int y1, input int x2, input int y2,
                         input int x3, input int y3, input int by);
        pippos_x1 = 12'(x1); pippos_y1 = 12'(y1);
        pippos_x2 = 12'(x2); pippos_y2 = 12'(y2);
        pippos_x3 = 12'(x3); pippos_y3 = 12'(y3);
        bpos_y    = 12'(by);
    endtask

    task automatic back_to_idle();
        @(negedge clk);
        is_start = 1'b0;
        restart  = is_over;
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
    endtask

    // Static inputs, scan starts at pipe 1: first hitting pipe in 1,2,3 order
    // wins; a border violation is seen on the pipe-1 sample.
    task automatic run_case(input string name, input int x1, input int y1, input int x2,
                            input int y2, input int x3, input int y3, input int by);
        bit exp_over;
        int exp_idx, lat, pulses;
        exp_over = 1'b1;
        if (model_hit(x1, y1, by))      exp_idx = 1;
        else if (model_border(by))      exp_idx = 0;
        else if (model_hit(x2, y2, by)) exp_idx = 2;
        else if (model_hit(x3, y3, by)) exp_idx = 3;
        else begin exp_over = 1'b0; exp_idx = 0; end
        @(negedge clk);
        drive(x1, y1, x2, y2, x3, y3, by);
        is_start = 1'b1;
        lat = 0; pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (hit_valid) pulses++;
            if (is_over && lat == 0) lat = c;
        end
        n_cmp++;
        if (is_over !== exp_over) begin
            n_bad++;
            $display("FAIL %s is_over: got %0b want %0b (by=%0d)", name, is_over, exp_over, by);
        end
        n_cmp++;
        if (hit_idx !== 2'(exp_idx)) begin
            n_bad++;
            $display("FAIL %s hit_idx: got %0d want %0d", name, hit_idx, exp_idx);
        end
        n_cmp++;
        if (pulses != (exp_over ? 1 : 0)) begin
            n_bad++;
            $display("FAIL %s hit_valid pulses: got %0d want %0d", name, pulses, exp_over ? 1 : 0);
        end
        if (exp_over) begin
            n_cmp++;
            if (lat == 0 || lat > 6) begin
                n_bad++;
                $display("FAIL %s latency: got %0d want 1..6 cycles", name, lat);
            end
        end
        back_to_idle();
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({is_over, hit_valid, hit_idx} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset outputs: got %b want 0000", {is_over, hit_valid, hit_idx});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_gap_pass();
        bit seen;
        seen = 1'b0;
        drive(300, 400, 0, 0, 0, 0, 400);
        is_start = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (is_over || hit_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL gap_pass is_over: got 1 want 0");
        end
        back_to_idle();
    endtask

    task automatic test_pipe_hit();
        run_case("pipe2_hit", 0, 400, 300, 400, 0, 400, 200);
    endtask

    task automatic test_edge_respawn();
        run_case("gap_top_edge", 300, 400, 0, 0, 0, 0, 326);
        run_case("gap_bot_edge", 1200, 400, 300, 400, 0, 0, 474);
        run_case("inside_gap", 300, 400, 0, 0, 0, 0, 327);
        run_case("respawn_x0", 0, 400, 0, 400, 0, 400, 326);
    endtask

    task automatic test_restart();
        @(negedge clk);
        drive(300, 400, 0, 0, 0, 0, 100);
        is_start = 1'b1;
        repeat (8) @(negedge clk);
        // OVER ignores is_start and bird moves
        is_start = 1'b0;
        bpos_y = 12'd400;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (is_over !== 1'b1 || hit_idx !== 2'd1) begin
            n_bad++;
            $display("FAIL over_hold: got over=%0b idx=%0d want over=1 idx=1", is_over, hit_idx);
        end
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        n_cmp++;
        if (is_over !== 1'b0 || hit_idx !== 2'd0) begin
            n_bad++;
            $display("FAIL restart_clear: got over=%0b idx=%0d want over=0 idx=0", is_over, hit_idx);
        end
        bpos_y = 12'd100;
        is_start = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (is_over !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_rerun is_over: got %0b want 1", is_over);
        end
        back_to_idle();
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 300, 400, 600);
        is_start = 1'b1;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({is_over, hit_valid, hit_idx} !== 4'b0) begin
            n_bad++;
            $display("FAIL async_reset outputs: got %b want 0000", {is_over, hit_valid, hit_idx});
        end
        is_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_case("after_reset", 0, 0, 0, 0, 300, 400, 600);
    endtask

    task automatic test_border();
        run_case("border_top", 1200, 400, 1200, 400, 1200, 400, 10);
        run_case("border_bottom", 1200, 400, 1200, 400, 1200, 400, 752);
        run_case("border_inside", 1200, 400, 1200, 400, 1200, 400, 751);
    endtask

    task automatic test_random();
        int xs[3], ys[3], by;
        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < 3; k++) begin
                case ($urandom_range(0, 3))
                    0:       xs[k] = 0;
                    1:       xs[k] = 1200;
                    default: xs[k] = int'($urandom_range(220, 380));
                endcase
                ys[k] = int'($urandom_range(100, 700));
            end
            by = int'($urandom_range(0, 790));
            run_case("random", xs[0], ys[0], xs[1], ys[1], xs[2], ys[2], by);
        end
    endtask

    initial begin
        test_reset();
        test_gap_pass();
        test_pipe_hit();
        test_edge_respawn();
        test_restart();
        test_async_reset();
        test_border();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
